// File: rtl/obf_key_pkg.sv
// Shared types and helpers for the obfuscation key loader.
// Optional parity stage is enabled by defining OBF_KEY_LOADER_PARITY_EN.
package obf_key_pkg;

  localparam int KEY_W_DEFAULT   = 2;
  localparam int TIMEOUT_DEFAULT = 16;

  // Encodings are pinned so the state register decodes identically in both builds
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
`ifdef OBF_KEY_LOADER_PARITY_EN
    ST_PARITY = 3'd2,
`endif
    ST_COMMIT = 3'd3,
    ST_LOCKED = 3'd4,
    ST_ERROR  = 3'd5
  } obf_key_state_t;

  // Zero-extension leaves parity unchanged, so any narrower vector may be passed in
  function automatic logic even_parity(input logic [63:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/obf_key_shift_reg.sv
// Indexed shadow register that collects serial key bits before an atomic commit.
// Used unchanged whether or not OBF_KEY_LOADER_PARITY_EN is defined.
module obf_key_shift_reg
  import obf_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT,
  parameter int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_bit,
  output logic [KEY_W-1:0] shadow
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shadow <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < KEY_W; i++) begin
        if (wr_idx == IDX_W'(i)) shadow[i] <= wr_bit;
      end
    end
  end

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader feeding the locked core's key bus; key_out changes only on commit.
// Define OBF_KEY_LOADER_PARITY_EN to require a trailing even-parity bit per load.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT,
  parameter bit RELOAD_OK = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_locked,
  output logic             load_err,
  output logic             busy
);

  localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  obf_key_state_t   state, next_state;
  logic [IDX_W-1:0] cnt;
  logic [TMR_W-1:0] timer;
  logic [KEY_W-1:0] shadow;

  logic start_load, shadow_wr, timer_clr, timer_inc, commit, set_err;

  obf_key_shift_reg #(
    .KEY_W(KEY_W),
    .IDX_W(IDX_W)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .clear (start_load),
    .wr_en (shadow_wr),
    .wr_idx(cnt),
    .wr_bit(key_bit),
    .shadow(shadow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      timer      <= '0;
      key_out    <= '0;
      key_locked <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (start_load) begin
        cnt      <= '0;
        timer    <= '0;
        load_err <= 1'b0;
      end else begin
        if (shadow_wr) cnt <= cnt + 1'b1;
        if (timer_clr) timer <= '0;
        else if (timer_inc) timer <= timer + 1'b1;
      end
      if (set_err) load_err <= 1'b1;
      if (commit) begin
        key_out    <= shadow;
        key_locked <= 1'b1;
      end
    end
  end

  // A restart request wins over a bit presented in the same cycle
  always_comb begin
    next_state = state;
    key_ready  = 1'b0;
    start_load = 1'b0;
    shadow_wr  = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    commit     = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_start) begin
          start_load = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        key_ready = 1'b1;
        if (key_start) begin
          start_load = 1'b1;
        end else if (key_valid) begin
          shadow_wr = 1'b1;
          timer_clr = 1'b1;
          if (cnt == IDX_W'(KEY_W - 1)) begin
`ifdef OBF_KEY_LOADER_PARITY_EN
            next_state = ST_PARITY;
`else
            next_state = ST_COMMIT;
`endif
          end
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          next_state = ST_ERROR;
        end else begin
          timer_inc = 1'b1;
        end
      end
`ifdef OBF_KEY_LOADER_PARITY_EN
      ST_PARITY: begin
        key_ready = 1'b1;
        if (key_start) begin
          start_load = 1'b1;
          next_state = ST_SHIFT;
        end else if (key_valid) begin
          timer_clr  = 1'b1;
          next_state = even_parity(64'({shadow, key_bit})) ? ST_ERROR : ST_COMMIT;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          next_state = ST_ERROR;
        end else begin
          timer_inc = 1'b1;
        end
      end
`endif
      ST_COMMIT: begin
        commit     = 1'b1;
        next_state = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (RELOAD_OK && key_start) begin
          start_load = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_ERROR: begin
        set_err    = 1'b1;
        next_state = key_locked ? ST_LOCKED : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE) && (state != ST_LOCKED);

endmodule
